// File: rtl/riscv_defines.sv
// Shared RV32M decode types for the iterative multiply/divide sequencer.
package riscv_defines;

   localparam int unsigned MDU_OP_WIDTH = 3;

   // Encodings follow RV32M funct3 order.
   typedef enum logic [2:0] {
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE, CALC, SIGN, DONE
   } mdu_state_e;

endpackage

// File: rtl/mdu_iter_dp.sv
// Radix-2 shift-add multiply / restoring divide datapath; the sequencer drives all control.
module mdu_iter_dp #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic             negate_i,
   input  logic             sel_hi_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH:0]     add_a, add_b;
   logic [WIDTH+1:0]   sum;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   half;

   // Divide: subtract via inverted operand plus carry-in; carry out means no borrow.
   always_comb begin
      add_a  = is_div_i ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b  = is_div_i ? ~{1'b0, b_q} : {1'b0, b_q};
      sum    = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div_i};
      div_ge = sum[WIDTH+1];

      acc_d = acc_q;
      if (load_i) begin
         acc_d = {{WIDTH{1'b0}}, a_i};
      end else if (step_i) begin
         if (is_div_i) begin
            acc_d = {(div_ge ? sum[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                     acc_q[WIDTH-2:0], div_ge};
         end else begin
            acc_d = {(acc_q[0] ? sum[WIDTH:0] : {1'b0, acc_q[2*WIDTH-1:WIDTH]}),
                     acc_q[WIDTH-1:1]};
         end
      end
   end

   // Product is negated as a whole; quotient/remainder are negated after selection.
   always_comb begin
      prod = negate_i ? -acc_q : acc_q;
      half = sel_hi_i ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      if (is_div_i) begin
         res_o = negate_i ? -half : half;
      end else begin
         res_o = sel_hi_i ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         if (load_i) begin
            b_q <= b_i;
         end
      end
   end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle RV32M sequencer: FSM, iteration counter, fast-path detection and result register.
module mdu_seq_ctrl
   import riscv_defines::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    kill_i,
   input  logic [MDU_OP_WIDTH-1:0] operator_i,
   input  logic [WIDTH-1:0]        operand_a_i,
   input  logic [WIDTH-1:0]        operand_b_i,
   output logic [WIDTH-1:0]        result_o,
   output logic                    done_o,
   output logic                    busy_o,
   output logic                    stall_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mdu_op_e          op_q, op_d, op_in;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             sa, sb, neg_in, fast, load, step, sel_hi;
   logic [WIDTH-1:0] a_mag, b_mag, fast_val, dp_res;

   // Accept-time decode: magnitudes, result sign and the single-cycle special cases.
   always_comb begin
      op_in  = mdu_op_e'(operator_i);
      sa     = (op_in inside {MULH, MULHSU, DIV, REM}) && operand_a_i[WIDTH-1];
      sb     = (op_in inside {MULH, DIV, REM}) && operand_b_i[WIDTH-1];
      a_mag  = sa ? -operand_a_i : operand_a_i;
      b_mag  = sb ? -operand_b_i : operand_b_i;
      neg_in = (op_in == REM) ? sa : (sa ^ sb);
      fast   = 1'b0;
      fast_val = '0;
      if (operator_i[2]) begin
         if (operand_b_i == '0) begin
            fast     = 1'b1;
            fast_val = operator_i[1] ? operand_a_i : '1;
         end else if ((op_in inside {DIV, REM}) && operand_a_i == MIN_VAL &&
                      operand_b_i == '1) begin
            fast     = 1'b1;
            fast_val = operator_i[1] ? '0 : MIN_VAL;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      load     = 1'b0;
      step     = 1'b0;
      if (kill_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_d  = op_in;
                  neg_d = neg_in;
                  if (fast) begin
                     result_d = fast_val;
                     state_d  = DONE;
                  end else begin
                     load    = 1'b1;
                     cnt_d   = CNT_W'(WIDTH - 1);
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               step = 1'b1;
               if (cnt_q == '0) begin
                  state_d = SIGN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            SIGN: begin
               result_d = dp_res;
               state_d  = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign sel_hi = op_q[2] ? op_q[1] : (op_q != MUL);

   mdu_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load),
      .step_i   (step),
      .is_div_i (op_q[2]),
      .negate_i (neg_q),
      .sel_hi_i (sel_hi),
      .a_i      (a_mag),
      .b_i      (b_mag),
      .res_o    (dp_res)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= MUL;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;
   assign done_o   = (state_q == DONE) && !kill_i;
   assign busy_o   = (state_q != IDLE);
   assign stall_o  = start_i && !done_o;

endmodule
